// File: rtl/ax_burst_gen.sv
// ax_burst_gen: issues a programmed number of AXI Ax bursts with a fixed
// address stride, an idle gap before each burst, and a cap on bursts that
// have been issued but not yet retired.
//
// Handshake: ax_valid_o rises in ISSUE, and ax_data_o is then held stable.
// Both stay put until the cycle where ax_ready_i is also high. resp_i is a
// one-cycle pulse per retired burst.
//
// ax_channel_t is a packed type whose low bits are laid out MSB..LSB as
// {addr, len[7:0], size[2:0], burst[1:0], id[IdWidth-1:0], nsaid[3:0]}.
// Any further fields must sit above addr; they are driven to zero.
module ax_burst_gen #(
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned CntWidth       = 16,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned NumIds         = 4,
  parameter type         ax_channel_t   = logic,
  localparam int unsigned OutWidth      = $clog2(MaxOutstanding + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  output logic                 ready_o,
  input  logic [AddrWidth-1:0] cfg_addr_i,
  input  logic [AddrWidth-1:0] cfg_stride_i,
  input  logic [7:0]           cfg_len_i,
  input  logic [2:0]           cfg_size_i,
  input  logic [1:0]           cfg_burst_i,
  input  logic [3:0]           cfg_nsaid_i,
  input  logic [CntWidth-1:0]  cfg_count_i,
  input  logic [15:0]          cfg_delay_i,
  input  logic                 abort_i,
  output logic                 ax_valid_o,
  output ax_channel_t          ax_data_o,
  input  logic                 ax_ready_i,
  input  logic                 resp_i,
  output logic [OutWidth-1:0]  outstanding_o,
  output logic [CntWidth-1:0]  issued_o,
  output logic                 done_o
);

  localparam int unsigned IdWidth      = (NumIds > 1) ? $clog2(NumIds) : 1;
  localparam int unsigned PayloadWidth = AddrWidth + 8 + 3 + 2 + IdWidth + 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE, S_DRAIN} state_e;

  state_e                state_q, state_d;
  logic [AddrWidth-1:0]  addr_q, stride_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [3:0]            nsaid_q;
  logic [CntWidth-1:0]   count_q, issued_q;
  logic [15:0]           delay_cfg_q, delay_cnt_q;
  logic [OutWidth-1:0]   out_q, out_d;
  logic                  abort_q, done_q;

  logic                  start_acc, ax_hs, resp_acc, last_burst, throttled;
  logic [IdWidth-1:0]    ax_id;
  logic [PayloadWidth-1:0] payload;

  assign start_acc  = start_i && (state_q == S_IDLE);
  assign ax_hs      = (state_q == S_ISSUE) && ax_ready_i;
  // A response with nothing outstanding is spurious and must not underflow.
  assign resp_acc   = resp_i && (out_q != '0);
  assign last_burst = (issued_q + CntWidth'(1)) == count_q;
  assign throttled  = out_q >= OutWidth'(MaxOutstanding);
  assign ax_id      = (NumIds > 1) ? issued_q[IdWidth-1:0] : '0;
  assign payload    = {addr_q, len_q, size_q, burst_q, ax_id, nsaid_q};

  // Outstanding count after this cycle's issue/retire events.
  always_comb begin
    out_d = out_q;
    if (ax_hs && !resp_acc)      out_d = out_q + OutWidth'(1);
    else if (!ax_hs && resp_acc) out_d = out_q - OutWidth'(1);
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = (cfg_count_i == '0) ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (abort_i)                                state_d = S_DRAIN;
        else if (delay_cnt_q == '0 && !throttled)   state_d = S_ISSUE;
      end
      S_ISSUE: begin
        // An abort seen during ISSUE only takes effect once the burst is accepted.
        if (ax_hs) state_d = (abort_q || abort_i || last_burst) ? S_DRAIN : S_WAIT;
      end
      S_DRAIN: begin
        if (out_d == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state; payload is zero when not valid.
  always_comb begin
    ready_o       = (state_q == S_IDLE);
    ax_valid_o    = (state_q == S_ISSUE);
    ax_data_o     = '0;
    if (state_q == S_ISSUE) ax_data_o = ax_channel_t'(payload);
    outstanding_o = out_q;
    issued_o      = issued_q;
    done_o        = done_q;
  end

  // Run configuration, address walk, delay counter and counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q      <= '0;
      stride_q    <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      nsaid_q     <= '0;
      count_q     <= '0;
      issued_q    <= '0;
      delay_cfg_q <= '0;
      delay_cnt_q <= '0;
      out_q       <= '0;
      abort_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      out_q  <= out_d;
      done_q <= (state_q == S_DRAIN) && (state_d == S_IDLE);
      if (start_acc) begin
        addr_q      <= cfg_addr_i;
        stride_q    <= cfg_stride_i;
        len_q       <= cfg_len_i;
        size_q      <= cfg_size_i;
        burst_q     <= cfg_burst_i;
        nsaid_q     <= cfg_nsaid_i;
        count_q     <= cfg_count_i;
        delay_cfg_q <= cfg_delay_i;
        delay_cnt_q <= cfg_delay_i;
        issued_q    <= '0;
        abort_q     <= 1'b0;
      end else begin
        if (state_q == S_WAIT && delay_cnt_q != '0) delay_cnt_q <= delay_cnt_q - 16'd1;
        if (state_q == S_ISSUE && abort_i)          abort_q     <= 1'b1;
        if (ax_hs) begin
          addr_q      <= addr_q + stride_q;
          issued_q    <= issued_q + CntWidth'(1);
          delay_cnt_q <= delay_cfg_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_ax_burst_gen.sv
// Directed bench for ax_burst_gen: basic run, backpressure, throttling,
// abort, count=0, address wrap, resp at zero and mid-run reset.
module tb_ax_burst_gen;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [1:0]  id;
    logic [3:0]  nsaid;
  } ax_t;

  localparam int W = $bits(ax_t);

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic        ready_o;
  logic [63:0] cfg_addr_i, cfg_stride_i;
  logic [7:0]  cfg_len_i;
  logic [2:0]  cfg_size_i;
  logic [1:0]  cfg_burst_i;
  logic [3:0]  cfg_nsaid_i;
  logic [15:0] cfg_count_i, cfg_delay_i;
  logic        abort_i;
  logic        ax_valid_o;
  ax_t         ax_data_o;
  logic        ax_ready_i;
  logic        resp_i;
  logic [1:0]  outstanding_o;
  logic [15:0] issued_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] held;

  ax_burst_gen #(
    .AddrWidth(64), .CntWidth(16), .MaxOutstanding(2), .NumIds(4), .ax_channel_t(ax_t)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .ready_o(ready_o),
    .cfg_addr_i(cfg_addr_i), .cfg_stride_i(cfg_stride_i), .cfg_len_i(cfg_len_i),
    .cfg_size_i(cfg_size_i), .cfg_burst_i(cfg_burst_i), .cfg_nsaid_i(cfg_nsaid_i),
    .cfg_count_i(cfg_count_i), .cfg_delay_i(cfg_delay_i), .abort_i(abort_i),
    .ax_valid_o(ax_valid_o), .ax_data_o(ax_data_o), .ax_ready_i(ax_ready_i),
    .resp_i(resp_i), .outstanding_o(outstanding_o), .issued_o(issued_o), .done_o(done_o)
  );

  // Clock and watchdog.
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [63:0] a, input logic [1:0] id);
    return {a, cfg_len_i, cfg_size_i, cfg_burst_i, id, cfg_nsaid_i};
  endfunction

  // Scoreboard: next expected payload must be on the bus with valid high.
  task automatic check_payload(input string tag);
    logic [W-1:0] e;
    e = '0;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    check({tag, "_valid"}, ax_valid_o, 1'b1);
    check(tag, ax_data_o, e);
  endtask

  task automatic start_run(input logic [63:0] a, input logic [63:0] s,
                           input logic [15:0] cnt, input logic [15:0] dly);
    cfg_addr_i   = a;
    cfg_stride_i = s;
    cfg_count_i  = cnt;
    cfg_delay_i  = dly;
    start_i      = 1'b1;
    tick();
    start_i      = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; ax_ready_i = 1'b1; resp_i = 1'b0;
    cfg_addr_i = '0; cfg_stride_i = '0; cfg_len_i = 8'd3; cfg_size_i = 3'd2;
    cfg_burst_i = 2'd1; cfg_nsaid_i = 4'd5; cfg_count_i = '0; cfg_delay_i = '0;
    #1;
    check("rst_ready", ready_o, 1'b1);
    check("rst_valid", ax_valid_o, 1'b0);
    check("rst_data", ax_data_o, '0);
    check("rst_issued", issued_o, 16'd0);
    check("rst_out", outstanding_o, 2'd0);
    check("rst_done", done_o, 1'b0);
    tick(); tick();
    rst_ni = 1'b1;
    tick();

    // Basic run: three bursts, resp two cycles after each handshake.
    exp_q.push_back(mk(64'h1000, 2'd0));
    exp_q.push_back(mk(64'h11000, 2'd1));
    exp_q.push_back(mk(64'h21000, 2'd2));
    start_run(64'h1000, 64'h10000, 16'd3, 16'd0);           // c+1
    check("basic_c1_valid", ax_valid_o, 1'b0);
    check("basic_c1_ready", ready_o, 1'b0);
    tick(); check_payload("basic_b0");                      // c+2
    tick(); check("basic_c3_valid", ax_valid_o, 1'b0);     // c+3
    check("basic_c3_issued", issued_o, 16'd1);
    check("basic_c3_out", outstanding_o, 2'd1);
    tick(); check_payload("basic_b1"); resp_i = 1'b1;       // c+4: handshake + resp
    tick(); resp_i = 1'b0;                                  // c+5
    check("simul_hs_resp_out", outstanding_o, 2'd1);
    check("basic_c5_issued", issued_o, 16'd2);
    tick(); check_payload("basic_b2"); resp_i = 1'b1;       // c+6
    tick(); resp_i = 1'b0;                                  // c+7
    check("basic_c7_valid", ax_valid_o, 1'b0);
    check("basic_c7_done", done_o, 1'b0);
    tick(); resp_i = 1'b1;                                  // c+8
    tick(); resp_i = 1'b0;                                  // c+9
    check("basic_done", done_o, 1'b1);
    check("basic_ready", ready_o, 1'b1);
    check("basic_issued", issued_o, 16'd3);
    check("basic_out", outstanding_o, 2'd0);
    tick(); check("basic_done_once", done_o, 1'b0);

    // Backpressure with a delay of 2: valid at c+4, held five cycles.
    ax_ready_i = 1'b0;
    start_run(64'h2000, 64'h100, 16'd1, 16'd2);             // c+1
    tick(); tick();                                         // c+3
    check("bp_delay_valid", ax_valid_o, 1'b0);
    tick();                                                 // c+4
    held = mk(64'h2000, 2'd0);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_held", ax_valid_o, 1'b1);
      check("bp_payload_held", ax_data_o, held);
      check("bp_issued_held", issued_o, 16'd0);
      tick();
    end
    check("bp_valid_at_ready", ax_valid_o, 1'b1);
    ax_ready_i = 1'b1;
    tick();
    check("bp_issued", issued_o, 16'd1);
    check("bp_valid_drop", ax_valid_o, 1'b0);
    resp_i = 1'b1;
    tick(); resp_i = 1'b0;
    check("bp_done", done_o, 1'b1);

    // Throttle: cap of 2 outstanding, count 4, responses released by hand.
    exp_q.push_back(mk(64'h3000, 2'd0));
    exp_q.push_back(mk(64'h3040, 2'd1));
    exp_q.push_back(mk(64'h3080, 2'd2));
    exp_q.push_back(mk(64'h30C0, 2'd3));
    start_run(64'h3000, 64'h40, 16'd4, 16'd0);
    tick(); check_payload("thr_b0");
    tick();
    tick(); check_payload("thr_b1");
    for (int i = 0; i < 4; i++) begin
      tick();
      check("thr_hold_valid", ax_valid_o, 1'b0);
      check("thr_hold_out", outstanding_o, 2'd2);
      check("thr_hold_issued", issued_o, 16'd2);
      check("thr_hold_ready", ready_o, 1'b0);
    end
    resp_i = 1'b1;
    tick(); resp_i = 1'b0;
    check("thr_release_out", outstanding_o, 2'd1);
    tick(); check_payload("thr_b2");
    tick(); check("thr_out2", outstanding_o, 2'd2);
    tick(); check("thr_hold2_valid", ax_valid_o, 1'b0);
    resp_i = 1'b1;
    tick(); resp_i = 1'b0;
    tick(); check_payload("thr_b3");
    tick();
    check("thr_issued", issued_o, 16'd4);
    check("thr_drain_out", outstanding_o, 2'd2);
    resp_i = 1'b1;
    tick(); tick(); resp_i = 1'b0;
    check("thr_done", done_o, 1'b1);
    check("exp_q_empty", exp_q.size(), 0);

    // Resp with nothing outstanding must not underflow.
    resp_i = 1'b1;
    tick(); resp_i = 1'b0;
    check("resp_at_zero", outstanding_o, 2'd0);

    // Abort during ISSUE with ready low.
    start_run(64'h4000, 64'h8, 16'd5, 16'd0);
    tick(); check("abort_b0", ax_data_o, mk(64'h4000, 2'd0));
    tick(); ax_ready_i = 1'b0;
    tick(); check("abort_b1", ax_data_o, mk(64'h4008, 2'd1));
    abort_i = 1'b1;
    tick(); abort_i = 1'b0;
    check("abort_valid_held", ax_valid_o, 1'b1);
    tick(); check("abort_valid_held2", ax_valid_o, 1'b1);
    ax_ready_i = 1'b1;
    tick();
    check("abort_no_more_valid", ax_valid_o, 1'b0);
    check("abort_issued", issued_o, 16'd2);
    tick(); check("abort_no_more_valid2", ax_valid_o, 1'b0);
    check("abort_not_done", done_o, 1'b0);
    resp_i = 1'b1;
    tick(); tick(); resp_i = 1'b0;
    check("abort_done", done_o, 1'b1);
    check("abort_issued_final", issued_o, 16'd2);

    // count=0: straight through DRAIN to IDLE.
    tick();
    start_run(64'h0, 64'h0, 16'd0, 16'd0);
    check("cnt0_valid", ax_valid_o, 1'b0);
    check("cnt0_ready", ready_o, 1'b0);
    tick();
    check("cnt0_done", done_o, 1'b1);
    check("cnt0_ready_back", ready_o, 1'b1);

    // Address wrap.
    start_run(64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 16'd2, 16'd0);
    tick(); check("wrap_b0", ax_data_o, mk(64'hFFFF_FFFF_FFFF_FFF0, 2'd0));
    tick();
    tick(); check("wrap_b1", ax_data_o, mk(64'h10, 2'd1));
    tick(); resp_i = 1'b1;
    tick(); tick(); resp_i = 1'b0;
    check("wrap_done", done_o, 1'b1);

    // Asynchronous reset while in ISSUE.
    start_run(64'h5000, 64'h10, 16'd3, 16'd0);
    tick();
    tick(); ax_ready_i = 1'b0;
    tick(); check("rst_mid_valid_before", ax_valid_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_mid_valid", ax_valid_o, 1'b0);
    check("rst_mid_data", ax_data_o, '0);
    check("rst_mid_ready", ready_o, 1'b1);
    check("rst_mid_out", outstanding_o, 2'd0);
    #2 rst_ni = 1'b1;
    tick();
    check("rst_after_ready", ready_o, 1'b1);
    check("rst_after_issued", issued_o, 16'd0);
    check("rst_after_out", outstanding_o, 2'd0);
    check("rst_after_done", done_o, 1'b0);
    check("rst_after_valid", ax_valid_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
